// File: rtl/cpu_pkg.sv
// Shared CPU types: default register file geometry and
// the register index and data word typedefs.
package cpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: per-register busy bits, operand masking,
// outstanding-producer count. Honours REGFILE_ZERO_REG_EN.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] mark_reg,
    input  logic              mark_en,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              all_idle
);

    localparam int NREG = 2**ADDR_W;
    localparam int CW   = ADDR_W + 1;

    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_cnt;

    logic [NREG-1:0] w_set_raw;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_nxt;
    logic            w_inc;
    logic            w_dec;

    assign w_set_raw = mark_en ? (NREG'(1) << mark_reg) : '0;
    assign w_clr     = reg_write ? (NREG'(1) << write_reg) : '0;

`ifdef REGFILE_ZERO_REG_EN
    assign w_set = w_set_raw & ~NREG'(1);
`else
    assign w_set = w_set_raw;
`endif

    // A new producer wins over a retiring one on the same register.
    assign w_nxt = w_set | (r_busy & ~w_clr);

    // At most one mark and one writeback per cycle, so each is 0/1.
    assign w_inc = |(w_set & ~r_busy);
    assign w_dec = |(w_clr & r_busy & ~w_set);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_nxt;
            r_cnt  <= r_cnt + CW'(w_inc) - CW'(w_dec);
        end
    end

    assign busy1 = r_busy[read_reg1]
                 & ~(reg_write && (write_reg == read_reg1));
    assign busy2 = r_busy[read_reg2]
                 & ~(reg_write && (write_reg == read_reg2));

    assign busy_cnt = r_cnt;
    assign all_idle = (r_cnt == '0);

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with bypass and busy scoreboard.
// Optional hardwired-zero r0 via REGFILE_ZERO_REG_EN.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] mark_reg,
    input  logic              mark_en,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              all_idle
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];

    logic w_we;
    logic w_byp1;
    logic w_byp2;
    logic w_zero1;
    logic w_zero2;

`ifdef REGFILE_ZERO_REG_EN
    assign w_we    = reg_write && (write_reg != '0);
    assign w_zero1 = (read_reg1 == '0);
    assign w_zero2 = (read_reg2 == '0);
`else
    assign w_we    = reg_write;
    assign w_zero1 = 1'b0;
    assign w_zero2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (w_we) begin
            r_mem[write_reg] <= write_data;
        end
    end

    assign w_byp1 = reg_write && (write_reg == read_reg1);
    assign w_byp2 = reg_write && (write_reg == read_reg2);

    always_comb begin
        read_data1 = r_mem[read_reg1];
        read_data2 = r_mem[read_reg2];
        if (w_byp1) read_data1 = write_data;
        if (w_byp2) read_data2 = write_data;
        if (w_zero1) read_data1 = '0;
        if (w_zero2) read_data2 = '0;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .write_reg (write_reg),
        .reg_write (reg_write),
        .mark_reg  (mark_reg),
        .mark_en   (mark_en),
        .busy1     (busy1),
        .busy2     (busy2),
        .busy_cnt  (busy_cnt),
        .all_idle  (all_idle)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, sequences,
// and random traffic against an array-based reference model.
module tb_regfile_sb;
    import cpu_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst;
    reg_idx_t read_reg1, read_reg2;
    word_t    read_data1, read_data2;
    logic     busy1, busy2;
    reg_idx_t write_reg;
    word_t    write_data;
    logic     reg_write;
    reg_idx_t mark_reg;
    logic     mark_en;
    logic [4:0] busy_cnt;
    logic     all_idle;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .busy1      (busy1),
        .busy2      (busy2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .mark_reg   (mark_reg),
        .mark_en    (mark_en),
        .busy_cnt   (busy_cnt),
        .all_idle   (all_idle)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    word_t m_mem  [16];
    bit    m_busy [16];

    typedef struct {
        logic     rst;
        logic     we;
        reg_idx_t wreg;
        word_t    wdata;
        logic     me;
        reg_idx_t mreg;
        reg_idx_t rr1;
        reg_idx_t rr2;
        word_t    e_rd1;
        logic     e_b1;
        int       e_cnt;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int m_rd(input reg_idx_t r);
        if (ZR && r == 0) return 0;
        if (reg_write && write_reg == r) return int'(write_data);
        return int'(m_mem[r]);
    endfunction

    function automatic int m_bz(input reg_idx_t r);
        if (ZR && r == 0) return 0;
        if (reg_write && write_reg == r) return 0;
        return m_busy[r] ? 1 : 0;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int k = 0; k < 16; k++) if (m_busy[k]) c++;
        return c;
    endfunction

    task automatic apply(input logic r, input logic we,
                         input reg_idx_t wr, input word_t wd,
                         input logic me, input reg_idx_t mr,
                         input reg_idx_t r1, input reg_idx_t r2);
        rst = r; reg_write = we; write_reg = wr; write_data = wd;
        mark_en = me; mark_reg = mr;
        read_reg1 = r1; read_reg2 = r2;
        #1;
        if (chk_en) begin
            chk("rd1", int'(read_data1), m_rd(r1));
            chk("rd2", int'(read_data2), m_rd(r2));
            chk("busy1", int'(busy1), m_bz(r1));
            chk("busy2", int'(busy2), m_bz(r2));
            chk("busy_cnt", int'(busy_cnt), m_cnt());
            chk("all_idle", int'(all_idle), m_cnt() == 0 ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_mem[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            if (reg_write && !(ZR && write_reg == 0))
                m_mem[write_reg] = write_data;
            if (reg_write) m_busy[write_reg] = 1'b0;
            if (mark_en && !(ZR && mark_reg == 0))
                m_busy[mark_reg] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic we,
                        input reg_idx_t wr, input word_t wd,
                        input logic me, input reg_idx_t mr,
                        input reg_idx_t r1, input reg_idx_t r2);
        apply(r, we, wr, wd, me, mr, r1, r2);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            m_mem[k] = '0;
            m_busy[k] = 1'b0;
        end

        // rst we wr wdata me mr rr1 rr2 | rd1 b1 cnt
        vt[0]  = '{0,1,5,16'h1111,0,0,5,5, 16'h1111,0,0};
        vt[1]  = '{0,0,0,16'h0000,0,0,5,5, 16'h1111,0,0};
        vt[2]  = '{0,1,5,16'h2222,0,0,5,5, 16'h2222,0,0};
        vt[3]  = '{0,0,0,16'h0000,0,0,5,5, 16'h2222,0,0};
        vt[4]  = '{0,0,0,16'h0000,1,7,7,7, 16'h0000,0,0};
        vt[5]  = '{0,0,0,16'h0000,1,7,7,7, 16'h0000,1,1};
        vt[6]  = '{0,0,0,16'h0000,0,0,7,7, 16'h0000,1,1};
        vt[7]  = '{0,1,7,16'h0042,0,0,7,7, 16'h0042,0,1};
        vt[8]  = '{0,0,0,16'h0000,0,0,7,7, 16'h0042,0,0};
        vt[9]  = '{0,0,0,16'h0000,1,4,4,4, 16'h0000,0,0};
        vt[10] = '{0,1,4,16'h4444,1,4,4,4, 16'h4444,0,1};
        vt[11] = '{0,0,0,16'h0000,1,2,4,4, 16'h4444,1,1};
        vt[12] = '{0,1,2,16'h0202,1,9,2,2, 16'h0202,0,2};
        vt[13] = '{0,0,0,16'h0000,0,0,9,2, 16'h0000,1,2};
        vt[14] = '{0,0,0,16'h0000,0,0,2,2, 16'h0202,0,2};
        vt[15] = '{1,1,3,16'hFFFF,0,0,4,4, 16'h4444,1,2};
        vt[16] = '{0,0,0,16'h0000,0,0,4,4, 16'h0000,0,0};

        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 1, 2);
        chk("reset_cnt", int'(busy_cnt), 0);
        chk("reset_idle", int'(all_idle), 1);
        tick();

        for (int i = 0; i < 17; i++) begin
            apply(vt[i].rst, vt[i].we, vt[i].wreg, vt[i].wdata,
                  vt[i].me, vt[i].mreg, vt[i].rr1, vt[i].rr2);
            chk($sformatf("vec%0d_rd1", i), int'(read_data1),
                int'(vt[i].e_rd1));
            chk($sformatf("vec%0d_b1", i), int'(busy1),
                int'(vt[i].e_b1));
            chk($sformatf("vec%0d_cnt", i), int'(busy_cnt),
                vt[i].e_cnt);
            tick();
        end

        for (int i = 0; i < 16; i++)
            step(0, 1, reg_idx_t'(i), word_t'(i), 0, 0, 0, 0);
        step(1, 1, 3, 16'hFFFF, 1, 6, 3, 3);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(i));
            chk($sformatf("rst_clear_r%0d", i), int'(read_data1), 0);
        end
        chk("rst_clear_cnt", int'(busy_cnt), 0);
        chk("rst_clear_idle", int'(all_idle), 1);

        for (int i = 0; i < 16; i++) begin
            step(0, 1, reg_idx_t'(i), word_t'(16'hA000 + i),
                 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(i));
            chk($sformatf("sweep_rd1_r%0d", i), int'(read_data1),
                (ZR && i == 0) ? 0 : 16'hA000 + i);
            chk($sformatf("sweep_rd2_r%0d", i), int'(read_data2),
                (ZR && i == 0) ? 0 : 16'hA000 + i);
        end

        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, 1, reg_idx_t'(i), 0, 0);
        chk("full_cnt", int'(busy_cnt), ZR ? 15 : 16);
        chk("full_idle", int'(all_idle), 0);
        for (int i = 0; i < 16; i++)
            step(0, 1, reg_idx_t'(i), word_t'(i), 0, 0, 0, 0);
        chk("drain_cnt", int'(busy_cnt), 0);
        chk("drain_idle", int'(all_idle), 1);
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 0, 1, reg_idx_t'(i), 0, 0);
        chk("five_cnt", int'(busy_cnt), 5);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt", int'(busy_cnt), 0);
        chk("rst_idle", int'(all_idle), 1);

        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 63) == 0,
                 1'($urandom), reg_idx_t'($urandom),
                 word_t'($urandom), 1'($urandom),
                 reg_idx_t'($urandom), reg_idx_t'($urandom),
                 reg_idx_t'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 16x16 two-read/one-write register file. It generalises data width and register count, and adds a synchronous clear. It also adds same-cycle write-to-read bypass and a per-register busy scoreboard with an outstanding-producer counter. The block sits in the CPU decode stage: decode reads operands and marks destinations busy, and writeback retires results.

Parameters:
DATA_W, 16, data width of every register and data port
ADDR_W, 4, register index width; register count NREG = 2**ADDR_W

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
read_reg1  in  ADDR_W  read port 1 index
read_reg2  in  ADDR_W  read port 2 index
read_data1  out  DATA_W  read port 1 data (combinational)
read_data2  out  DATA_W  read port 2 data (combinational)
busy1  out  1  read_reg1 has an outstanding producer
busy2  out  1  read_reg2 has an outstanding producer
write_reg  in  ADDR_W  writeback index
write_data  in  DATA_W  writeback data
reg_write  in  1  writeback enable
mark_reg  in  ADDR_W  destination index being issued
mark_en  in  1  set busy for mark_reg
busy_cnt  out  ADDR_W+1  number of registers currently busy
all_idle  out  1  busy_cnt == 0

Behaviour:
- Reset: one clock, synchronous, active-high, and it overrides all other inputs. After the posedge with rst=1: every register = 0, every busy bit = 0, busy_cnt = 0, all_idle = 1. With rst=1 and reg_write=1 in the same cycle, nothing is written.
- Write: at posedge, if reg_write and not rst, then mem[write_reg] <= write_data.
- Reads: asynchronous, zero latency. read_dataN = mem[read_regN].
- Bypass: if reg_write=1 and write_reg==read_regN, then read_dataN = write_data in the same cycle. Both ports may bypass at once.
- Scoreboard, per register i, at posedge:
  - set = mark_en && mark_reg==i
  - clr = reg_write && write_reg==i
  - set && clr: busy stays or becomes 1. The new producer wins; the write still updates data.
  - clr only: busy <= 0.
  - set only: busy <= 1.
  - Marking an already-busy register leaves busy=1 with no double count.
  - Writing a non-busy register leaves busy=0.
- busyN output = busy[read_regN] & ~(reg_write && write_reg==read_regN). A bypassed operand reads as ready. A mark issued in the same cycle does not affect busyN until the next cycle.
- busy_cnt: registered; equals the popcount of the busy vector after each edge. Implemented as an incremental counter: +1 on a 0->1 transition, -1 on a 1->0 transition. Both transitions on different registers in one cycle leave it unchanged. Range 0..NREG, never wraps.
- all_idle: combinational from busy_cnt.

Optional Feature:
REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to 0.
  - Writes to index 0 are discarded.
  - read_dataN = 0 for index 0, including when the bypass condition holds.
  - mark_en to index 0 never sets busy, and busy1/busy2 are 0 for index 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W/ADDR_W default constants
  - a reg_idx_t typedef (ADDR_W bits)
  - a word_t typedef (DATA_W bits)
- One natural sub-module, regfile_scoreboard: the busy vector, busyN masking, busy_cnt and all_idle.
- Storage and bypass stay in the top level.

Test Plan:
1. Reset clear: write r0..r15 = i, assert rst one cycle with reg_write=1, write_reg=3, write_data=16'hFFFF. Read all registers -> all 0, busy_cnt=0, all_idle=1.
2. Write/read sweep: for i=0..15 write data 16'hA000+i, then read with read_reg1=read_reg2=i. Both ports return 16'hA000+i; with ZERO_REG_EN, index 0 returns 0.
3. Bypass: mem[5]=16'h1111; in one cycle drive reg_write=1, write_reg=5, write_data=16'h2222, read_reg1=5. read_data1=16'h2222 in that cycle; after the edge, mem[5]=16'h2222.
4. Scoreboard basics: mark r7 -> busy1=1 next cycle (read_reg1=7), busy_cnt=1. Mark r7 again -> busy_cnt still 1. Write r7 with 16'h0042 -> busy1=0 in the write cycle, read_data1=16'h0042, busy_cnt=0 after the edge.
5. Simultaneous set/clear: r4 busy; mark_reg=4 and write_reg=4 in the same cycle -> r4 busy=1, data updated, busy_cnt unchanged. Mark r9 while writing busy r2 -> busy_cnt unchanged, r9 busy, r2 idle.
6. Counter bounds: mark all 16 registers over 16 cycles -> busy_cnt=16, all_idle=0. Write all 16 -> busy_cnt=0, all_idle=1. Assert rst while busy_cnt=5 -> 0 after the edge.
